mux_rr_nx1: RTL

- Parametrised N-input, W-bit registered multiplexer with per-channel valid/ready handshake.
- Two modes: fixed select (driven by `sel`) or round-robin among valid channels.
- One output register stage.
- Successor to the combinational 2:1 data mux; sits in front of the shift-divider datapath to merge operand streams from several producers.

---
 rtl/mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/mux_rr_nx1.sv | 99 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin / fixed-select N:1 registered mux.
package mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Fallback ceiling-log2 for tools without $clog2.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting just after `last`, wrapping.
module rr_arbiter #(
   parameter  int NUM_CH = 4,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  last,
   output logic [NUM_CH-1:0] grant,
   output logic [SEL_W-1:0]  grant_idx,
   output logic              any
);

   always_comb begin
      logic [SEL_W-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = SEL_W'((int'(last) + k) % NUM_CH);
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/mux_rr_nx1.sv
// N-input registered mux with valid/ready per channel; fixed-select or round-robin grant.
module mux_rr_nx1
   import mux_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int DATA_W = 8,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic [NUM_CH-1:0]        in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_ch,
   input  logic                     out_ready
);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0]  out_ch_q, out_ch_d;
   logic [SEL_W-1:0]  last_q, last_d;

   logic [NUM_CH-1:0] rr_grant, fix_grant, grant;
   logic [SEL_W-1:0]  rr_idx, fix_idx, grant_idx;
   logic              rr_any, fix_any, any;
   logic              load_en;
   logic [DATA_W-1:0] ch_data [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
   end

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req       (in_valid),
      .last      (last_q),
      .grant     (rr_grant),
      .grant_idx (rr_idx),
      .any       (rr_any)
   );

   // sel may exceed NUM_CH-1 when NUM_CH is not a power of two; that is simply no grant.
   always_comb begin
      fix_grant = '0;
      fix_any   = 1'b0;
      fix_idx   = sel;
      if (int'(sel) < NUM_CH) begin
         if (in_valid[sel]) begin
            fix_grant[sel] = 1'b1;
            fix_any        = 1'b1;
         end
      end
   end

   always_comb begin
      load_en   = !out_valid_q || out_ready;
      grant     = (mode == MODE_RR) ? rr_grant : fix_grant;
      grant_idx = (mode == MODE_RR) ? rr_idx   : fix_idx;
      any       = (mode == MODE_RR) ? rr_any   : fix_any;
      in_ready  = load_en ? grant : '0;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      last_d      = last_q;
      if (load_en) begin
         out_valid_d = any;
         if (any) begin
            out_data_d = ch_data[grant_idx];
            out_ch_d   = grant_idx;
            last_d     = grant_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         last_q      <= SEL_W'(NUM_CH - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         last_q      <= last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule
